// File: rtl/btn_op_select.sv
// ============================================================================
// Module   : btn_op_select
// Purpose  : Debounces five push buttons and turns presses into an op select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_op_select #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnR,
  input  logic       btnL,
  output logic [2:0] op,
  output logic       op_strobe,
  output logic       held,
  output logic       clr_pulse,
  output logic [4:0] btn_db
);

  localparam int              CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ADD = 3'd0,
    ST_SUB = 3'd1,
    ST_MUL = 3'd2,
    ST_QUO = 3'd3,
    ST_REM = 3'd4
  } state_t;

  // Bit order everywhere is {C,U,D,R,L}.
  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q;
  logic [4:0]    sync2_q;
  logic [4:0]    db_q;
  logic [4:0]    db_d;
  logic [4:0]    db_prev_q;
  logic [4:0]    press;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  state_t        state_q;
  state_t        state_d;
  logic          strobe_q;
  logic          strobe_d;
  logic          clr_q;
  logic          clr_d;

  assign btn_raw = {btnC, btnU, btnD, btnR, btnL};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
      state_q   <= ST_ADD;
      strobe_q  <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      clr_q     <= clr_d;
    end
  end

  // A level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  // Simultaneous presses: highest priority wins, the rest are dropped.
  always_comb begin
    state_d  = state_q;
    strobe_d = |press;
    clr_d    = press[4];
    if (press[4]) begin
      state_d = ST_ADD;
    end else if (press[3]) begin
      state_d = ST_SUB;
    end else if (press[2]) begin
      state_d = ST_MUL;
    end else if (press[1]) begin
      state_d = ST_QUO;
    end else if (press[0]) begin
      state_d = ST_REM;
    end
  end

  always_comb begin
    held = 1'b0;
    case (state_q)
      ST_SUB:  held = db_q[3];
      ST_MUL:  held = db_q[2];
      ST_QUO:  held = db_q[1];
      ST_REM:  held = db_q[0];
      default: held = 1'b0;
    endcase
  end

  assign op        = state_q;
  assign op_strobe = strobe_q;
  assign clr_pulse = clr_q;
  assign btn_db    = db_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_op_select.sv
// ============================================================================
// Module   : tb_btn_op_select
// Purpose  : Self-checking bench for btn_op_select with DB_CYCLES = 4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_btn_op_select;

  localparam int DB = 4;

  logic       clk;
  logic       clr_n;
  logic       btnC, btnU, btnD, btnR, btnL;
  logic [2:0] op;
  logic       op_strobe;
  logic       held;
  logic       clr_pulse;
  logic [4:0] btn_db;

  btn_op_select #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .btnC      (btnC),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnR      (btnR),
    .btnL      (btnL),
    .op        (op),
    .op_strobe (op_strobe),
    .held      (held),
    .clr_pulse (clr_pulse),
    .btn_db    (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw history, per-button run lengths, pending press events.
  logic [4:0] m_hist [$];
  logic [4:0] m_db;
  logic [4:0] m_pend;
  int         m_run [5];
  int         m_op;
  logic       m_strobe;
  logic       m_clr;

  typedef struct {
    logic [4:0] btns;
    int         hold;
    int         exp_op;
    int         exp_strobes;
    int         exp_clrs;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btnC, btnU, btnD, btnR, btnL} = b;
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_db     = '0;
    m_pend   = '0;
    m_op     = 0;
    m_strobe = 1'b0;
    m_clr    = 1'b0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
  endtask

  function automatic int m_held();
    if (m_op == 0) return 0;
    return int'(m_db[4 - m_op]);
  endfunction

  task automatic model_edge();
    logic [4:0] raw, syn, nd, ev;
    if (!clr_n) begin
      model_reset();
      return;
    end
    raw = {btnC, btnU, btnD, btnR, btnL};
    ev  = m_pend;
    m_strobe = (ev != 5'b0);
    m_clr    = ev[4];
    if      (ev[4]) m_op = 0;
    else if (ev[3]) m_op = 1;
    else if (ev[2]) m_op = 2;
    else if (ev[1]) m_op = 3;
    else if (ev[0]) m_op = 4;
    // The level seen by the debouncer is the raw sample from two edges ago.
    syn = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 5'b0;
    nd  = m_db;
    for (int i = 0; i < 5; i++) begin
      if (syn[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] >= DB) begin
          nd[i]    = syn[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pend = nd & ~m_db;
    m_db   = nd;
    m_hist.push_back(raw);
    if (m_hist.size() > 2) void'(m_hist.pop_front());
  endtask

  task automatic check_outputs();
    check("op",        int'(op),        m_op);
    check("op_strobe", int'(op_strobe), int'(m_strobe));
    check("clr_pulse", int'(clr_pulse), int'(m_clr));
    check("held",      int'(held),      m_held());
    check("btn_db",    int'(btn_db),    int'(m_db));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    int first, strobes, clrs, both, fall;

    vecs[0] = '{5'b01000, 10, 1, 1, 0};  // U
    vecs[1] = '{5'b00100, 10, 2, 1, 0};  // D
    vecs[2] = '{5'b00011, 10, 3, 1, 0};  // R+L together: R wins
    vecs[3] = '{5'b01000,  3, 3, 0, 0};  // 3-cycle U glitch
    vecs[4] = '{5'b00001, 10, 4, 1, 0};  // L
    vecs[5] = '{5'b10000, 10, 0, 1, 1};  // C from REM
    vecs[6] = '{5'b11000, 10, 0, 1, 1};  // C beats U
    vecs[7] = '{5'b00111, 10, 2, 1, 0};  // D beats R, L
    vecs[8] = '{5'b00100, 10, 2, 1, 0};  // re-press of current op
    vecs[9] = '{5'b00010, 30, 3, 1, 0};  // long hold, one strobe

    set_btns(5'b0);
    clr_n = 1'b0;
    model_reset();
    #1;
    check("rst_op",     int'(op),        0);
    check("rst_strobe", int'(op_strobe), 0);
    check("rst_btn_db", int'(btn_db),    0);
    repeat (2) tick();
    @(negedge clk);
    clr_n = 1'b1;

    // Clean D press: first strobe on edge DB+3, held drops DB+2 edges after release.
    set_btns(5'b00100);
    first = -1; strobes = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (op_strobe) begin
        strobes++;
        if (first < 0) first = e;
      end
    end
    check("d_first_strobe_edge", first, DB + 3);
    check("d_strobe_count",      strobes, 1);
    check("d_op",                int'(op), 2);
    set_btns(5'b0);
    fall = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (!held && fall < 0) fall = e;
    end
    check("d_held_fall_edge", fall, DB + 2);

    foreach (vecs[k]) begin
      strobes = 0; clrs = 0; both = 0;
      set_btns(vecs[k].btns);
      for (int c = 0; c < vecs[k].hold; c++) begin
        tick();
        strobes += int'(op_strobe);
        clrs    += int'(clr_pulse);
        both    += int'(op_strobe & clr_pulse);
      end
      set_btns(5'b0);
      for (int c = 0; c < 8; c++) begin
        tick();
        strobes += int'(op_strobe);
        clrs    += int'(clr_pulse);
        both    += int'(op_strobe & clr_pulse);
      end
      check($sformatf("vec%0d_op", k),      int'(op), vecs[k].exp_op);
      check($sformatf("vec%0d_strobes", k), strobes,  vecs[k].exp_strobes);
      check($sformatf("vec%0d_clrs", k),    clrs,     vecs[k].exp_clrs);
      check($sformatf("vec%0d_both", k),    both,     vecs[k].exp_clrs);
      if (vecs[k].exp_op == 0) check($sformatf("vec%0d_held", k), int'(held), 0);
    end

    // Reset mid-debounce with U held; press is re-seen after release.
    set_btns(5'b01000);
    repeat (5) tick();
    clr_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_op",     int'(op),        0);
    check("mid_rst_strobe", int'(op_strobe), 0);
    check("mid_rst_held",   int'(held),      0);
    check("mid_rst_clr",    int'(clr_pulse), 0);
    check("mid_rst_btn_db", int'(btn_db),    0);
    tick();
    @(negedge clk);
    clr_n = 1'b1;
    first = -1; strobes = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (op_strobe) begin
        strobes++;
        if (first < 0) first = e;
      end
    end
    check("rst_u_first_edge", first, DB + 3);
    check("rst_u_strobes",    strobes, 1);
    check("rst_u_op",         int'(op), 1);

    // Release and re-press U: second strobe, op stays SUB.
    set_btns(5'b0);
    repeat (8) tick();
    set_btns(5'b01000);
    strobes = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      strobes += int'(op_strobe);
    end
    check("repress_u_strobes", strobes, 1);
    check("repress_u_op",      int'(op), 1);

    // Random bouncing buttons and occasional resets against the model.
    set_btns(5'b0);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) set_btns(5'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        clr_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        tick();
        clr_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_op_select.md
BTN_OP_SELECT -- requirements
Module: btn_op_select

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 1000000 (10 ms at 100 MHz), the number of consecutive cycles a synchronized button level must differ from its debounced level before that level is accepted; legal range 2 to 2^24.
REQ-002 Port clk, input, 1 bit, SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-003 Port clr_n, input, 1 bit, SHALL be the reset; reset is asynchronous and active-low.
REQ-004 Ports btnC, btnU, btnD, btnR, btnL, inputs, 1 bit each, SHALL be the raw, asynchronous, bouncing push-button levels (1 = pressed).
REQ-005 Port op, output, 3 bits, SHALL be the selected operation: 0 = ADD, 1 = SUB (btnU), 2 = MUL (btnD), 3 = QUO (btnR), 4 = REM (btnL); 5 to 7 are never driven.
REQ-006 Port op_strobe, output, 1 bit, SHALL be a one-cycle pulse on each accepted press, including btnC.
REQ-007 Port held, output, 1 bit, SHALL be the debounced level of the button that selected the current op.
REQ-008 Port clr_pulse, output, 1 bit, SHALL be a one-cycle pulse on an accepted btnC press.
REQ-009 Port btn_db, output, 5 bits, SHALL give the debounced levels {C,U,D,R,L}, with bit 4 = C.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each button SHALL have its own debounce counter, $clog2(DB_CYCLES) bits wide, which behaves as follows:
- Synchronized level equals debounced level: the counter clears to 0.
- Levels differ and the counter is below DB_CYCLES-1: the counter increments.
- Levels differ and the counter equals DB_CYCLES-1: the debounced level takes the synchronized level and the counter clears.
REQ-012 A raw level held steady from before edge 1 SHALL appear on btn_db after edge DB_CYCLES+2.
REQ-013 A raw pulse or glitch shorter than DB_CYCLES cycles SHALL never change btn_db.
REQ-014 A press event SHALL be a 0-to-1 transition of a btn_db bit. Releases (1-to-0 transitions) SHALL generate no event and leave op unchanged.
REQ-015 op, op_strobe, and clr_pulse SHALL be registered and SHALL update on the edge after the btn_db rise. Total latency from a clean raw press to op_strobe high is therefore DB_CYCLES+3 edges.
REQ-016 The selection FSM SHALL have states ADD, SUB, MUL, QUO, REM, and transitions as follows:
- Any state: a U/D/R/L press moves to SUB/MUL/QUO/REM.
- Any state: a C press moves to ADD.
- op SHALL equal the state encoding.
REQ-017 When several press events occur on the same edge, exactly one SHALL be accepted, with priority C > U > D > R > L. The others SHALL be discarded and not deferred.
REQ-018 A press of the button for the already-selected op SHALL still pulse op_strobe, which restarts the downstream display scroll; op stays unchanged.
REQ-019 held SHALL be 0 in state ADD. In other states it SHALL follow btn_db of the owning button (U/D/R/L) combinationally from the registered debounced level.
REQ-020 clr_pulse SHALL assert only together with op_strobe on a C press. It SHALL never assert for U/D/R/L.
REQ-021 A button held continuously SHALL produce exactly one op_strobe; a new strobe requires a debounced release and then a re-press.

Reset
REQ-022 While clr_n = 0, all outputs SHALL be held at reset values: op = 0 (ADD), op_strobe = 0, held = 0, clr_pulse = 0, btn_db = 0. The synchronizers and counters SHALL also be held at 0.
REQ-023 Reset asserted mid-debounce or mid-strobe SHALL abort the operation immediately: any pending pulse is lost and no event fires after release.
REQ-024 After clr_n rises, a button already held high SHALL be treated as a new press and strobe after DB_CYCLES+3 edges.

Verification (DB_CYCLES = 4)
REQ-025 Clean btnD press from edge 1, held 20 cycles -> op_strobe high only after edge 7; op = 2 from edge 7; held = 1 until 6 edges after release, then 0; exactly one strobe.
REQ-026 btnU glitch of 3 cycles, then low -> btn_db[3] never rises, op stays 0, and no strobe occurs.
REQ-027 btnR and btnL raised on the same cycle -> a single strobe; op = 3; btnL dropped, no later REM event.
REQ-028 op = 4, then a btnC press -> op = 0, with op_strobe = 1 and clr_pulse = 1 for exactly one cycle together; held = 0.
REQ-029 btnU held, clr_n pulsed low for 1 cycle at edge 5 -> all outputs 0 during reset; strobe with op = 1 occurs 7 edges after clr_n rises.
REQ-030 op = 1, btnU released then pressed again -> second op_strobe with op unchanged at 1.
